// File: rtl/ex_m_pipe_stage.sv
// EX/M pipeline register stage built as a two-entry in-order skid buffer.
// The head entry drives the M side, and a second (skid) entry absorbs one
// extra transfer while M stalls. All state updates on the falling edge of clk.
// Optional feature: define EX_M_BUBBLE_CNT_EN to add the bubble_cnt output,
// which counts idle edges where M was ready but nothing was presented.
module ex_m_pipe_stage #(
    parameter int PC_SIZE   = 18,
    parameter int DATA_SIZE = 32,
    parameter int CTRL_W    = 6,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic [DATA_SIZE-1:0] in_alu_result,
    input  logic [DATA_SIZE-1:0] in_rt_data,
    input  logic [PC_SIZE-1:0]   in_pcplus8,
    input  logic [4:0]           in_wr_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [DATA_SIZE-1:0] out_alu_result,
    output logic [DATA_SIZE-1:0] out_rt_data,
    output logic [PC_SIZE-1:0]   out_pcplus8,
    output logic [4:0]           out_wr_out,
    input  logic                 flush,
    output logic [1:0]           occupancy
`ifdef EX_M_BUBBLE_CNT_EN
    ,
    output logic [CNT_W-1:0]     bubble_cnt
`endif
);

    localparam int PW = CTRL_W + 2 * DATA_SIZE + PC_SIZE + 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   skid_q, skid_d;
    logic            inReady_q, inReady_d;
    logic [PW-1:0]   inPayload;
    logic [PW-1:0]   outPayload;
    logic            push;
    logic            pop;

    assign inPayload = {in_ctrl, in_alu_result, in_rt_data, in_pcplus8, in_wr_out};
    assign push      = in_valid && inReady_q;
    assign pop       = (state_q != EMPTY) && out_ready;

    // Next-state and next-entry selection. Flush wipes both entries and drops any
    // concurrent push; otherwise the buffer behaves as a strict two-deep FIFO,
    // with the skid entry promoted to head whenever the head is consumed.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            head_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_d  = inPayload;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_d = inPayload;
                    end else if (push) begin
                        skid_d  = inPayload;
                        state_d = FULL;
                    end else if (pop) begin
                        head_d  = '0;
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_d  = skid_q;
                        skid_d  = '0;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    head_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
        inReady_d = (state_d != FULL);
    end

    // State and entry registers; reset beats flush, push and pop, and in_ready
    // is a flop of its own so out_ready can never reach it combinationally.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            head_q    <= '0;
            skid_q    <= '0;
            inReady_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            skid_q    <= skid_d;
            inReady_q <= inReady_d;
        end
    end

    assign in_ready   = inReady_q;
    assign out_valid  = (state_q != EMPTY);
    assign occupancy  = state_q;
    assign outPayload = out_valid ? head_q : '0;
    assign {out_ctrl, out_alu_result, out_rt_data, out_pcplus8, out_wr_out} = outPayload;

`ifdef EX_M_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubbleCnt_q;

    // Count edges where M could have taken data but the stage was empty;
    // saturates rather than wrapping and only reset clears it.
    always_ff @(negedge clk) begin
        if (rst) begin
            bubbleCnt_q <= '0;
        end else if (!out_valid && out_ready && (bubbleCnt_q != {CNT_W{1'b1}})) begin
            bubbleCnt_q <= bubbleCnt_q + 1'b1;
        end
    end

    assign bubble_cnt = bubbleCnt_q;
`endif

endmodule

// File: tb/tb_ex_m_pipe_stage.sv
// Self-checking bench for ex_m_pipe_stage. A queue-based model of the buffer
// is advanced at every falling edge; a compare process checks the DUT against
// it on every rising edge, and directed scenarios add literal expectations.
module tb_ex_m_pipe_stage;

    typedef struct packed {
        logic [5:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [17:0] pc;
        logic [4:0]  wr;
    } payload_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_ctrl = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_rt_data = '0;
    logic [17:0] in_pcplus8 = '0;
    logic [4:0]  in_wr_out = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_ctrl;
    logic [31:0] out_alu_result;
    logic [31:0] out_rt_data;
    logic [17:0] out_pcplus8;
    logic [4:0]  out_wr_out;
    logic        flush = 1'b0;
    logic [1:0]  occupancy;
`ifdef EX_M_BUBBLE_CNT_EN
    logic [3:0]  bubble_cnt;
`endif

    int testsRun = 0;
    int testsFailed = 0;
    bit checkEn = 1'b0;

    payload_t modelQ[$];
    int       modelBubble = 0;

    ex_m_pipe_stage #(
        .PC_SIZE(18), .DATA_SIZE(32), .CTRL_W(6), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_alu_result(in_alu_result), .in_rt_data(in_rt_data),
        .in_pcplus8(in_pcplus8), .in_wr_out(in_wr_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_alu_result(out_alu_result), .out_rt_data(out_rt_data),
        .out_pcplus8(out_pcplus8), .out_wr_out(out_wr_out),
        .flush(flush), .occupancy(occupancy)
`ifdef EX_M_BUBBLE_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    // Free-running clock; the DUT acts on the falling edge, the bench samples on the rising one.
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [127:0] act, input logic [127:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one edge's worth of inputs, advance the model at the falling edge, return at the rising edge.
    task automatic applyStimulus(input bit v, input payload_t p, input bit rdy, input bit fl, input bit rs);
        bit push;
        bit pop;
        in_valid = v;
        {in_ctrl, in_alu_result, in_rt_data, in_pcplus8, in_wr_out} = p;
        out_ready = rdy;
        flush = fl;
        rst = rs;
        @(negedge clk);
        if (rs) begin
            modelQ.delete();
            modelBubble = 0;
        end else begin
            push = v && (modelQ.size() < 2);
            pop  = (modelQ.size() > 0) && rdy;
            if ((modelQ.size() == 0) && rdy && (modelBubble < 15)) modelBubble++;
            if (fl) begin
                modelQ.delete();
            end else begin
                if (pop) void'(modelQ.pop_front());
                if (push) modelQ.push_back(p);
            end
        end
        @(posedge clk);
    endtask

    // Compare every DUT output against the model's view of the buffer.
    task automatic checkOutput();
        payload_t expHead;
        expHead = (modelQ.size() > 0) ? modelQ[0] : '0;
        checkValue("out_valid", 128'(out_valid), 128'(modelQ.size() > 0));
        checkValue("in_ready", 128'(in_ready), 128'(modelQ.size() < 2));
        checkValue("occupancy", 128'(occupancy), 128'(modelQ.size()));
        checkValue("payload", 128'({out_ctrl, out_alu_result, out_rt_data, out_pcplus8, out_wr_out}), 128'(expHead));
`ifdef EX_M_BUBBLE_CNT_EN
        checkValue("bubble_cnt", 128'(bubble_cnt), 128'(modelBubble));
`endif
    endtask

    always @(posedge clk) begin
        if (checkEn) checkOutput();
    end

    function automatic payload_t mk(input logic [31:0] alu);
        payload_t p;
        p.ctrl = 6'b100011;
        p.alu  = alu;
        p.rt   = ~alu;
        p.pc   = 18'(alu * 8);
        p.wr   = 5'(alu);
        return p;
    endfunction

    function automatic payload_t rnd();
        payload_t p;
        p.ctrl = 6'($urandom);
        p.alu  = $urandom;
        p.rt   = $urandom;
        p.pc   = 18'($urandom);
        p.wr   = 5'($urandom);
        return p;
    endfunction

    initial begin
        payload_t z;
        payload_t c;
        z = '0;

        @(posedge clk);
        applyStimulus(1'b1, mk(32'h55), 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, z, 1'b0, 1'b0, 1'b1);
        checkEn = 1'b1;
        applyStimulus(1'b0, z, 1'b0, 1'b0, 1'b0);
        checkValue("reset_occ", 128'(occupancy), 128'd0);
        checkValue("reset_inready", 128'(in_ready), 128'd1);

        // Streaming: each word appears one edge after it is pushed.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, mk(32'(i)), 1'b1, 1'b0, 1'b0);
            checkValue("stream_alu", 128'(out_alu_result), 128'(i));
            checkValue("stream_occ", 128'(occupancy), 128'd1);
        end
        applyStimulus(1'b0, z, 1'b1, 1'b0, 1'b0);
        checkValue("drain_valid", 128'(out_valid), 128'd0);

        // Backpressure into the skid entry, then drain in order.
        applyStimulus(1'b1, mk(32'hA), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, mk(32'hB), 1'b0, 1'b0, 1'b0);
        checkValue("bp_occ", 128'(occupancy), 128'd2);
        checkValue("bp_inready", 128'(in_ready), 128'd0);
        checkValue("bp_hold", 128'(out_alu_result), 128'hA);
        applyStimulus(1'b1, mk(32'hE), 1'b0, 1'b0, 1'b0);
        checkValue("bp_hold2", 128'(out_alu_result), 128'hA);
        applyStimulus(1'b0, z, 1'b1, 1'b0, 1'b0);
        checkValue("bp_pop1", 128'(out_alu_result), 128'hB);
        checkValue("bp_inready1", 128'(in_ready), 128'd1);
        applyStimulus(1'b0, z, 1'b1, 1'b0, 1'b0);
        checkValue("bp_pop2", 128'(occupancy), 128'd0);

        // Flush while full with a simultaneous push.
        applyStimulus(1'b1, mk(32'h1), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, mk(32'h2), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, mk(32'hC), 1'b1, 1'b1, 1'b0);
        checkValue("flush_occ", 128'(occupancy), 128'd0);
        checkValue("flush_valid", 128'(out_valid), 128'd0);
        checkValue("flush_ctrl", 128'(out_ctrl), 128'd0);
        applyStimulus(1'b0, z, 1'b0, 1'b0, 1'b0);
        checkValue("flush_noC", 128'(out_valid), 128'd0);

        // Reset while full, then resume.
        applyStimulus(1'b1, mk(32'h3), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, mk(32'h4), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, mk(32'h5), 1'b1, 1'b0, 1'b1);
        checkValue("rst_alu", 128'(out_alu_result), 128'd0);
        checkValue("rst_inready", 128'(in_ready), 128'd1);
        checkValue("rst_occ", 128'(occupancy), 128'd0);
        applyStimulus(1'b1, mk(32'hD), 1'b0, 1'b0, 1'b0);
        checkValue("rst_resume", 128'(out_alu_result), 128'hD);

        // Control field integrity at extreme values.
        applyStimulus(1'b0, z, 1'b1, 1'b0, 1'b0);
        c.ctrl = 6'b110101;
        c.alu  = 32'hDEADBEEF;
        c.rt   = 32'h12345678;
        c.pc   = 18'h3FFFF;
        c.wr   = 5'd31;
        applyStimulus(1'b1, c, 1'b0, 1'b0, 1'b0);
        checkValue("ctrl_ctrl", 128'(out_ctrl), 128'b110101);
        checkValue("ctrl_wr", 128'(out_wr_out), 128'd31);
        checkValue("ctrl_pc", 128'(out_pcplus8), 128'h3FFFF);
        applyStimulus(1'b0, z, 1'b1, 1'b0, 1'b0);

`ifdef EX_M_BUBBLE_CNT_EN
        // Bubble counter saturates, survives flush, clears on reset.
        applyStimulus(1'b0, z, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, z, 1'b1, 1'b0, 1'b0);
        checkValue("bub_sat", 128'(bubble_cnt), 128'hF);
        applyStimulus(1'b0, z, 1'b1, 1'b1, 1'b0);
        checkValue("bub_flush", 128'(bubble_cnt), 128'hF);
        applyStimulus(1'b0, z, 1'b1, 1'b0, 1'b1);
        checkValue("bub_rst", 128'(bubble_cnt), 128'h0);
`endif

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 6, rnd(), $urandom_range(0, 9) < 6,
                          $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
        end

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
